// File: rtl/sample_proj_pkg.sv
// Shared constants and step classification for the walking-bit sequencer.
package sample_proj_pkg;

  localparam int TICKS_PER_MS = 10000;
  localparam int NUM_OUT      = 34;
  localparam int DONE_STEP    = NUM_OUT + 1;
  localparam int PRESC_W      = 14;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_ACTIVE = 2'd1,
    PH_DONE   = 2'd2
  } phase_e;

  // Step 0 is idle, the last step is the all-zero done step, the rest drive one pin.
  function automatic phase_e step_phase(input int unsigned step, input int unsigned done_step);
    phase_e ph;
    if (step == 32'd0) begin
      ph = PH_IDLE;
    end else if (step == done_step) begin
      ph = PH_DONE;
    end else begin
      ph = PH_ACTIVE;
    end
    return ph;
  endfunction

endpackage

// File: rtl/sample_proj_tick_gen.sv
// Step tick generator: base counter divides the clock to 1 ms strobes,
// the ms counter divides strobes by the live prescaler value.
module tick_gen
  import sample_proj_pkg::*;
#(
  parameter int TICKS_PER_MS = sample_proj_pkg::TICKS_PER_MS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] prescaler,
  output logic               tick
);

  localparam int BASE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(TICKS_PER_MS - 1);

  logic [BASE_W-1:0]  base_cnt_r;
  logic [PRESC_W-1:0] ms_cnt_r;
  logic               strobe_s;
  logic               ms_last_s;
  logic               tick_s;

  // Strobe and terminal-count decode; a counter already past a lowered prescaler counts as terminal
  always_comb begin
    strobe_s  = enable & (base_cnt_r == BASE_LAST);
    ms_last_s = 1'b0;
    if (prescaler != {PRESC_W{1'b0}}) begin
      ms_last_s = (ms_cnt_r >= (prescaler - PRESC_W'(1)));
    end else begin
      ms_last_s = 1'b0;
    end
    tick_s = strobe_s & ms_last_s & ~clear;
  end

  // Base counter: freezes while disabled, wraps at the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_cnt_r <= '0;
    end else if (clear) begin
      base_cnt_r <= '0;
    end else if (enable) begin
      if (base_cnt_r == BASE_LAST) begin
        base_cnt_r <= '0;
      end else begin
        base_cnt_r <= base_cnt_r + BASE_W'(1);
      end
    end else begin
      base_cnt_r <= base_cnt_r;
    end
  end

  // ms counter: advances on each strobe, wraps on the tick or when no prescaler is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt_r <= '0;
    end else if (clear) begin
      ms_cnt_r <= '0;
    end else if (strobe_s) begin
      if (ms_last_s || (prescaler == {PRESC_W{1'b0}})) begin
        ms_cnt_r <= '0;
      end else begin
        ms_cnt_r <= ms_cnt_r + PRESC_W'(1);
      end
    end else begin
      ms_cnt_r <= ms_cnt_r;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/sample_proj.sv
// Walking-bit sequencer top: step register plus registered one-hot/done decode.
module sample_proj
  import sample_proj_pkg::*;
#(
  parameter int TICKS_PER_MS = sample_proj_pkg::TICKS_PER_MS,
  parameter int NUM_OUT      = sample_proj_pkg::NUM_OUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               stop,
  input  logic [PRESC_W-1:0] prescaler,
  output logic               done,
  output logic [NUM_OUT-1:0] out
);

  localparam int STEP_W = $clog2(NUM_OUT + 2);
  localparam logic [STEP_W-1:0]  STEP_FIRST = STEP_W'(1);
  localparam logic [STEP_W-1:0]  STEP_DONE  = STEP_W'(NUM_OUT + 1);
  localparam logic [NUM_OUT-1:0] OUT_ONE    = NUM_OUT'(1);

  logic               tick_s;
  logic [STEP_W-1:0]  step_r;
  logic [STEP_W-1:0]  step_nxt_s;
  logic [NUM_OUT-1:0] out_r;
  logic [NUM_OUT-1:0] out_nxt_s;
  logic               done_r;
  logic               done_nxt_s;

  tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (stop),
    .prescaler(prescaler),
    .tick     (tick_s)
  );

  // Next step: stop wins, a tick advances, DONE goes straight back to the first pin
  always_comb begin
    step_nxt_s = step_r;
    if (stop) begin
      step_nxt_s = '0;
    end else if (tick_s) begin
      if (step_r == STEP_DONE) begin
        step_nxt_s = STEP_FIRST;
      end else begin
        step_nxt_s = step_r + STEP_W'(1);
      end
    end else begin
      step_nxt_s = step_r;
    end
  end

  // Output decode from the next step so out/done land on the same edge as the step
  always_comb begin
    out_nxt_s  = '0;
    done_nxt_s = 1'b0;
    case (step_phase(32'(step_nxt_s), 32'(STEP_DONE)))
      PH_IDLE: begin
        out_nxt_s  = '0;
        done_nxt_s = 1'b0;
      end
      PH_ACTIVE: begin
        out_nxt_s  = OUT_ONE << (step_nxt_s - STEP_W'(1));
        done_nxt_s = 1'b0;
      end
      PH_DONE: begin
        out_nxt_s  = '0;
        done_nxt_s = 1'b1;
      end
      default: begin
        out_nxt_s  = '0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Step and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      step_r <= step_nxt_s;
      out_r  <= out_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign out  = out_r;
  assign done = done_r;

endmodule

// File: tb/tb_sample_proj.sv
// Self-checking bench for sample_proj with a shortened base period.
module tb_sample_proj;

  localparam int T  = 10;
  localparam int NO = 34;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          stop;
  logic [13:0]   prescaler;
  logic          done;
  logic [NO-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;
  int model_n  = 0;

  sample_proj #(.TICKS_PER_MS(T), .NUM_OUT(NO)) dut (
    .clk      (tb_clk),
    .rst      (rst),
    .enable   (enable),
    .stop     (stop),
    .prescaler(prescaler),
    .done     (done),
    .out      (out)
  );

  always #50 tb_clk = ~tb_clk;

  // Reference: count enabled edges since idle; step follows from the elapsed whole periods.
  always @(posedge tb_clk or posedge rst) begin
    if (rst) model_n <= 0;
    else if (stop) model_n <= 0;
    else if (enable) model_n <= model_n + 1;
  end

  function automatic int exp_step(int n, int p);
    int q;
    if (p == 0) return 0;
    q = n / (T * p);
    if (q == 0) return 0;
    return ((q - 1) % (NO + 1)) + 1;
  endfunction

  function automatic logic [NO-1:0] step_to_out(int s);
    logic [NO-1:0] one;
    one = 1;
    if (s >= 1 && s <= NO) return one << (s - 1);
    return '0;
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    rst = 1'b1; enable = 1'b0; stop = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic chk(string name, logic [NO-1:0] exp_o, logic exp_d);
    n_checks++;
    if (out !== exp_o || done !== exp_d) begin
      n_fail++;
      $display("FAIL %s: out=%h done=%b expected out=%h done=%b", name, out, done, exp_o, exp_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; stop = 1'b0; prescaler = 14'd1;
    cycles(2);
    n_checks++;
    if (out !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: out=%h done=%b expected 0/0", out, done);
    end
    enable = 1'b0;
    rst = 1'b0;
    cycles(2);
    n_checks++;
    if (out !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: out=%h done=%b expected 0/0", out, done);
    end
  endtask

  task automatic test_walk(int p, int passes);
    logic [NO-1:0] exp_o;
    int s;
    do_reset();
    prescaler = 14'(p);
    enable = 1'b1;
    cycles(T * p - 1);
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL walk_latency_p%0d: out=%h expected 0 one cycle before first step", p, out);
    end
    cycles(2);
    for (int k = 0; k < (NO + 1) * passes; k++) begin
      s = (k % (NO + 1)) + 1;
      exp_o = '0;
      if (s <= NO) exp_o[s - 1] = 1'b1;
      n_checks++;
      if (out !== exp_o || done !== (s == NO + 1)) begin
        n_fail++;
        $display("FAIL walk_p%0d_k%0d: out=%h done=%b expected out=%h done=%b",
                 p, k, out, done, exp_o, (s == NO + 1));
      end
      if (k != (NO + 1) * passes - 1) cycles(T * p);
    end
    stop = 1'b1;
    cycles(1);
    n_checks++;
    if (out !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_stop_p%0d: out=%h done=%b expected 0/0", p, out, done);
    end
    stop = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_stop();
    do_reset();
    prescaler = 14'd1;
    enable = 1'b1;
    cycles(125);
    n_checks++;
    if (out !== 34'h800) begin
      n_fail++;
      $display("FAIL stop_pre: out=%h expected %h", out, 34'h800);
    end
    stop = 1'b1;
    cycles(1);
    n_checks++;
    if (out !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_clear: out=%h done=%b expected 0/0", out, done);
    end
    cycles(50);
    n_checks++;
    if (out !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_hold: out=%h done=%b expected 0/0", out, done);
    end
    stop = 1'b0;
    cycles(T - 1);
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL stop_restart_early: out=%h expected 0", out);
    end
    cycles(1);
    n_checks++;
    if (out !== 34'h1) begin
      n_fail++;
      $display("FAIL stop_restart: out=%h expected 1", out);
    end
  endtask

  task automatic test_enable_pause();
    do_reset();
    prescaler = 14'd1;
    enable = 1'b1;
    cycles(15);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(100);
      n_checks++;
      if (out !== 34'h1) begin
        n_fail++;
        $display("FAIL pause_hold_%0d: out=%h expected 1", i, out);
      end
    end
    enable = 1'b1;
    cycles(4);
    n_checks++;
    if (out !== 34'h1) begin
      n_fail++;
      $display("FAIL pause_resume_early: out=%h expected 1", out);
    end
    cycles(1);
    n_checks++;
    if (out !== 34'h2) begin
      n_fail++;
      $display("FAIL pause_resume_step: out=%h expected 2", out);
    end
  endtask

  task automatic test_prescaler_zero();
    do_reset();
    prescaler = 14'd0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycles(50);
      n_checks++;
      if (out !== '0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL presc_zero_%0d: out=%h done=%b expected 0/0", i, out, done);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_prescaler_change();
    do_reset();
    prescaler = 14'd5;
    enable = 1'b1;
    cycles(3 * T);
    prescaler = 14'd2;
    cycles(T - 1);
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL presc_change_early: out=%h expected 0", out);
    end
    cycles(1);
    n_checks++;
    if (out !== 34'h1) begin
      n_fail++;
      $display("FAIL presc_change_wrap: out=%h expected 1", out);
    end
    cycles(2 * T);
    n_checks++;
    if (out !== 34'h2) begin
      n_fail++;
      $display("FAIL presc_change_next: out=%h expected 2", out);
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 6; seg++) begin
      stop = 1'b1;
      prescaler = 14'($urandom_range(3, 1));
      cycles(1);
      stop = 1'b0;
      for (int c = 0; c < 500; c++) begin
        enable = ($urandom_range(99, 0) < 75);
        stop   = ($urandom_range(199, 0) < 2);
        cycles(1);
        chk("random", step_to_out(exp_step(model_n, int'(prescaler))),
            exp_step(model_n, int'(prescaler)) == NO + 1);
      end
      stop = 1'b0;
    end
    enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; stop = 1'b0; prescaler = 14'd0;
    test_reset();
    test_walk(1, 2);
    test_stop();
    test_walk(10, 2);
    test_enable_pause();
    test_prescaler_zero();
    test_prescaler_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
